muldiv_ctrl: RTL and testbench

Sequencing controller for the multi-cycle M-extension operations (MUL, DIV, DIVU, REM, REMU and their word forms) issued by the execute stage. It accepts one operation through a valid/ready handshake and runs an iterative radix-2 shift-add multiplier or restoring divider. It holds the result until the pipeline consumes it. Execute stalls on `in_ready`/`out_valid`. Writeback takes `result`.

---
 rtl/muldiv_ctrl_if.sv | 26 ++
 rtl/muldiv_ctrl.sv | 172 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// Execute-stage <-> multiply/divide controller bus.
// Request and response both use valid/ready: a transfer happens on the rising edge where valid and ready are both high. The sender holds valid and its payload until then. ready may not depend combinationally on valid.
interface muldiv_ctrl_if #(
   parameter int XLEN = 64
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      op;
   logic            is_word;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;

   modport master (
      output flush, in_valid, op, is_word, src_a, src_b, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  flush, in_valid, op, is_word, src_a, src_b, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative M-extension unit: radix-2 shift-add multiply and restoring divide.
// One operation at a time, accepted in IDLE, result held in DONE until consumed.
module muldiv_ctrl #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 7
) (
   input  logic          clk,
   input  logic          reset_n,
   muldiv_ctrl_if.slave  bus,
   output logic [1:0]    dbg_state_o
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_e;

   localparam logic [2:0] OP_MUL  = 3'd0;
   localparam logic [2:0] OP_DIV  = 3'd1;
   localparam logic [2:0] OP_DIVU = 3'd2;
   localparam logic [2:0] OP_REM  = 3'd3;
   localparam logic [2:0] OP_REMU = 3'd4;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic              word_q, word_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN-1:0]   acc_q, acc_d;
   logic              negq_q, negq_d;
   logic              negr_q, negr_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              signed_op, is_div, is_rem, sign_a, sign_b;
   logic [XLEN-1:0]   ea, eb, mag_a, mag_b, most_neg, fin;
   logic [XLEN:0]     trial, diff;

   function automatic logic [XLEN-1:0] wext(input logic w, input logic [XLEN-1:0] x);
      return w ? {{(XLEN-32){x[31]}}, x[31:0]} : x;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         word_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         word_q   <= word_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      word_d   = word_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      result_d = result_q;

      signed_op = (bus.op == OP_DIV) || (bus.op == OP_REM);
      is_div    = (bus.op >= OP_DIV) && (bus.op <= OP_REMU);
      is_rem    = (bus.op == OP_REM) || (bus.op == OP_REMU);
      if (bus.is_word) begin
         ea = signed_op ? {{(XLEN-32){bus.src_a[31]}}, bus.src_a[31:0]}
                        : {{(XLEN-32){1'b0}}, bus.src_a[31:0]};
         eb = signed_op ? {{(XLEN-32){bus.src_b[31]}}, bus.src_b[31:0]}
                        : {{(XLEN-32){1'b0}}, bus.src_b[31:0]};
         most_neg = {{(XLEN-31){1'b1}}, 31'b0};
      end else begin
         ea = bus.src_a;
         eb = bus.src_b;
         most_neg = {1'b1, {(XLEN-1){1'b0}}};
      end
      sign_a = signed_op & ea[XLEN-1];
      sign_b = signed_op & eb[XLEN-1];
      mag_a  = sign_a ? -ea : ea;
      mag_b  = sign_b ? -eb : eb;

      // Dividend is kept left-aligned in a_q so the next bit is always the MSB.
      trial = {acc_q, a_q[XLEN-1]};
      diff  = trial - {1'b0, b_q};

      case (op_q)
         OP_MUL:           fin = acc_q;
         OP_DIV, OP_DIVU:  fin = negq_q ? -a_q : a_q;
         OP_REM, OP_REMU:  fin = negr_q ? -acc_q : acc_q;
         default:          fin = '0;
      endcase

      if (bus.flush) begin
         state_d  = S_IDLE;
         result_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  op_d   = bus.op;
                  word_d = bus.is_word;
                  if (bus.op > OP_REMU) begin
                     result_d = '0;
                     state_d  = S_DONE;
                  end else if (is_div && eb == '0) begin
                     result_d = wext(bus.is_word, is_rem ? ea : '1);
                     state_d  = S_DONE;
                  end else if (signed_op && ea == most_neg && eb == '1) begin
                     result_d = wext(bus.is_word, is_rem ? '0 : ea);
                     state_d  = S_DONE;
                  end else begin
                     state_d = S_BUSY;
                     cnt_d   = bus.is_word ? CNT_W'(32) : CNT_W'(XLEN);
                     acc_d   = '0;
                     negq_d  = sign_a ^ sign_b;
                     negr_d  = sign_a;
                     if (bus.op == OP_MUL) begin
                        a_d = ea;
                        b_d = eb;
                     end else begin
                        a_d = bus.is_word ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
                        b_d = mag_b;
                     end
                  end
               end
            end
            S_BUSY: begin
               if (cnt_q == '0) begin
                  result_d = wext(word_q, fin);
                  state_d  = S_DONE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
                  if (op_q == OP_MUL) begin
                     if (b_q[0]) acc_d = acc_q + a_q;
                     a_d = a_q << 1;
                     b_d = b_q >> 1;
                  end else if (!diff[XLEN]) begin
                     acc_d = diff[XLEN-1:0];
                     a_d   = {a_q[XLEN-2:0], 1'b1};
                  end else begin
                     acc_d = trial[XLEN-1:0];
                     a_d   = {a_q[XLEN-2:0], 1'b0};
                  end
               end
            end
            S_DONE: begin
               if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.result    = result_q;
   assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, results, special cases, hold, flush, async reset.
module tb_muldiv_ctrl;
   localparam int XLEN = 64;
   localparam logic [2:0] OP_MUL = 3'd0, OP_DIV = 3'd1, OP_DIVU = 3'd2, OP_REM = 3'd3, OP_REMU = 3'd4;

   logic        clk;
   logic        reset_n;
   logic [1:0]  dbg_state;
   int          errors;
   int          checks;
   int          cyc;
   logic [XLEN-1:0] exp;
   logic [XLEN-1:0] exp_q[$];

   muldiv_ctrl_if #(.XLEN(XLEN)) bus ();

   muldiv_ctrl #(.XLEN(XLEN), .CNT_W(7)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_idle();
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = 3'd0; bus.is_word = 1'b0;
      bus.src_a = '0; bus.src_b = '0; bus.out_ready = 1'b0;
   endtask

   // Presents the request at negedge; it is taken on the following posedge (edge 0).
   task automatic issue(input logic [2:0] o, input logic w, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      @(negedge clk);
      bus.op = o; bus.is_word = w; bus.src_a = a; bus.src_b = b; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.src_a = {$urandom, $urandom};
      bus.src_b = {$urandom, $urandom};
   endtask

   // Counts edges after the accept edge until out_valid is seen (0 = valid right after accept).
   task automatic wait_valid(output int n);
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic consume();
      @(negedge clk); bus.out_ready = 1'b1;
      @(posedge clk); #1; bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      checks++; if (bus.result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result); end
      @(negedge clk); reset_n = 1'b1;
   endtask

   task automatic test_mul();
      issue(OP_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
      exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
      wait_valid(cyc);
      checks++; if (cyc !== 65) begin errors++; $display("FAIL mul_latency: got %0d expected 65", cyc); end
      exp = exp_q.pop_front();
      checks++; if (bus.result !== exp) begin errors++; $display("FAIL mul_result: got %h expected %h", bus.result, exp); end
      consume();
      // MULW: low 32 bits of 3 * 0xFFFFFFFF = 0xFFFFFFFD, sign-extended
      issue(OP_MUL, 1'b1, 64'h1_0000_0003, 64'h0000_0000_FFFF_FFFF);
      exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFD);
      wait_valid(cyc);
      checks++; if (cyc !== 33) begin errors++; $display("FAIL mulw_latency: got %0d expected 33", cyc); end
      exp = exp_q.pop_front();
      checks++; if (bus.result !== exp) begin errors++; $display("FAIL mulw_result: got %h expected %h", bus.result, exp); end
      consume();
   endtask

   task automatic test_div_rem();
      issue(OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
      exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFD);
      wait_valid(cyc);
      checks++; if (cyc !== 65) begin errors++; $display("FAIL div_latency: got %0d expected 65", cyc); end
      exp = exp_q.pop_front();
      checks++; if (bus.result !== exp) begin errors++; $display("FAIL div_result: got %h expected %h", bus.result, exp); end
      consume();
      issue(OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
      exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      wait_valid(cyc);
      exp = exp_q.pop_front();
      checks++; if (bus.result !== exp) begin errors++; $display("FAIL rem_result: got %h expected %h", bus.result, exp); end
      consume();
      issue(OP_REMU, 1'b0, 64'd17, 64'd5);
      exp_q.push_back(64'd2);
      wait_valid(cyc);
      exp = exp_q.pop_front();
      checks++; if (bus.result !== exp) begin errors++; $display("FAIL remu_result: got %h expected %h", bus.result, exp); end
      consume();
   endtask

   task automatic test_word();
      issue(OP_DIVU, 1'b1, 64'h1_0000_0010, 64'd3);
      exp_q.push_back(64'd5);
      wait_valid(cyc);
      checks++; if (cyc !== 33) begin errors++; $display("FAIL divuw_latency: got %0d expected 33", cyc); end
      exp = exp_q.pop_front();
      checks++; if (bus.result !== exp) begin errors++; $display("FAIL divuw_result: got %h expected %h", bus.result, exp); end
      consume();
      issue(OP_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
      exp_q.push_back(64'hFFFF_FFFF_8000_0000);
      wait_valid(cyc);
      checks++; if (cyc !== 0) begin errors++; $display("FAIL divw_ovf_latency: got %0d expected 0", cyc); end
      exp = exp_q.pop_front();
      checks++; if (bus.result !== exp) begin errors++; $display("FAIL divw_ovf_result: got %h expected %h", bus.result, exp); end
      consume();
      // REMW -7 % 2 on word operands = -1
      issue(OP_REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2);
      exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      wait_valid(cyc);
      checks++; if (cyc !== 33) begin errors++; $display("FAIL remw_latency: got %0d expected 33", cyc); end
      exp = exp_q.pop_front();
      checks++; if (bus.result !== exp) begin errors++; $display("FAIL remw_result: got %h expected %h", bus.result, exp); end
      consume();
   endtask

   task automatic test_div_zero();
      issue(OP_DIVU, 1'b0, 64'd5, 64'd0);
      exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      wait_valid(cyc);
      checks++; if (cyc !== 0) begin errors++; $display("FAIL divu0_latency: got %0d expected 0", cyc); end
      exp = exp_q.pop_front();
      checks++; if (bus.result !== exp) begin errors++; $display("FAIL divu0_result: got %h expected %h", bus.result, exp); end
      consume();
      issue(OP_REMU, 1'b0, 64'd5, 64'd0);
      exp_q.push_back(64'd5);
      wait_valid(cyc);
      checks++; if (cyc !== 0) begin errors++; $display("FAIL remu0_latency: got %0d expected 0", cyc); end
      exp = exp_q.pop_front();
      checks++; if (bus.result !== exp) begin errors++; $display("FAIL remu0_result: got %h expected %h", bus.result, exp); end
      consume();
      issue(3'd6, 1'b0, 64'd9, 64'd3);
      wait_valid(cyc);
      checks++; if (bus.result !== 64'd0) begin errors++; $display("FAIL reserved_result: got %h expected 0", bus.result); end
      consume();
   endtask

   task automatic test_hold_done();
      issue(OP_MUL, 1'b0, 64'd3, 64'd4);
      exp_q.push_back(64'd12);
      wait_valid(cyc);
      exp = exp_q.pop_front();
      @(negedge clk);
      bus.in_valid = 1'b1; bus.op = OP_DIVU; bus.src_a = 64'd100; bus.src_b = 64'd0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, bus.out_valid); end
         checks++; if (bus.result !== exp) begin errors++; $display("FAIL hold_result[%0d]: got %h expected %h", i, bus.result, exp); end
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
      end
      bus.in_valid = 1'b0;
      consume();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b expected 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
      issue(OP_REMU, 1'b0, 64'd17, 64'd5);
      checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL next_accept_state: got %0d expected 1", dbg_state); end
      wait_valid(cyc);
      checks++; if (bus.result !== 64'd2) begin errors++; $display("FAIL next_accept_result: got %h expected 2", bus.result); end
      consume();
   endtask

   task automatic test_flush();
      logic seen;
      issue(OP_DIV, 1'b0, 64'd100, 64'd7);
      repeat (9) @(posedge clk);
      @(negedge clk); bus.flush = 1'b1;
      @(posedge clk); #1; bus.flush = 1'b0;
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL flush_state: got %0d expected 0", dbg_state); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", bus.in_ready); end
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_valid: got %b expected 0", seen); end
      @(negedge clk);
      bus.flush = 1'b1; bus.in_valid = 1'b1; bus.op = OP_MUL; bus.src_a = 64'd2; bus.src_b = 64'd2;
      @(posedge clk); #1;
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL flush_beats_valid: got %0d expected 0", dbg_state); end
   endtask

   task automatic test_async_reset();
      issue(OP_MUL, 1'b0, 64'd6, 64'd7);
      repeat (5) @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL arst_busy_in_ready: got %b expected 1", bus.in_ready); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL arst_busy_state: got %0d expected 0", dbg_state); end
      @(negedge clk); reset_n = 1'b1;
      issue(OP_DIVU, 1'b0, 64'd5, 64'd0);
      #2 reset_n = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_done_valid: got %b expected 0", bus.out_valid); end
      checks++; if (bus.result !== 64'd0) begin errors++; $display("FAIL arst_done_result: got %h expected 0", bus.result); end
      @(negedge clk); reset_n = 1'b1;
      issue(OP_MUL, 1'b0, 64'd6, 64'd7);
      exp_q.push_back(64'd42);
      wait_valid(cyc);
      checks++; if (cyc !== 65) begin errors++; $display("FAIL post_reset_latency: got %0d expected 65", cyc); end
      exp = exp_q.pop_front();
      checks++; if (bus.result !== exp) begin errors++; $display("FAIL post_reset_result: got %h expected %h", bus.result, exp); end
      consume();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_mul();
      test_div_rem();
      test_word();
      test_div_zero();
      test_hold_done();
      test_flush();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
